// File: rtl/mem_arbiter_pkg.sv
// Shared defines for the memory arbiter.
//   state_t   : arbiter state codes; the same values are reported on busy
//   LEN_*     : mem_len encodings (3 is treated like LEN_W)
//   TRUE/FALSE: pipeline-wide boolean constants
//   len_bytes : byte count of a data access for a given mem_len
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single 8-bit RAM port between instruction fetch and the
// MEM stage. Multi-byte accesses run as consecutive single-byte RAM cycles,
// little-endian. Data accesses win over fetch; fetch can be aborted by a
// branch redirect (if_flush).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_pc/if_flush    fetch request, address, redirect
//   if_ready                 fetch can be accepted this cycle (combinational)
//   if_done/if_inst/if_pc_back  fetched word and its address, one-cycle pulse
//   mem_req/mem_we/mem_len/mem_addr/mem_wdata  data request
//   mem_done/mem_rdata       data completion pulse, zero-extended load data
//   busy                     0 idle, 1 fetching, 2 data access
//   ram_din/ram_dout/ram_a/ram_wr  byte-wide RAM port (read data one cycle late)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              if_flush,
  output logic              if_ready,
  output logic              if_done,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc_back,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [1:0]        busy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  state_t            state, state_d;
  logic [2:0]        cnt, cnt_d, cnt_inc;
  logic [2:0]        n_q, n_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] base_q, base_d, nxt_a;
  // byte 0 of store data goes out at grant, so only bytes 1..3 are kept
  logic [23:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;

  logic [ADDR_W-1:0] ram_a_d, if_pc_back_d;
  logic [7:0]        ram_dout_d;
  logic              ram_wr_d, if_done_d, mem_done_d;
  logic [31:0]       if_inst_d, mem_rdata_d;

  assign if_ready = (state == ST_IDLE) && !mem_req && !if_flush;
  assign busy     = state;

  assign cnt_inc = cnt + 3'd1;
  assign nxt_a   = base_q + ADDR_W'(cnt_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      n_q        <= '0;
      we_q       <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      ram_a      <= '0;
      ram_dout   <= '0;
      ram_wr     <= 1'b0;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
      if_inst    <= '0;
      if_pc_back <= '0;
      mem_rdata  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      n_q        <= n_d;
      we_q       <= we_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      ram_a      <= ram_a_d;
      ram_dout   <= ram_dout_d;
      ram_wr     <= ram_wr_d;
      if_done    <= if_done_d;
      mem_done   <= mem_done_d;
      if_inst    <= if_inst_d;
      if_pc_back <= if_pc_back_d;
      mem_rdata  <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    n_d          = n_q;
    we_d         = we_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    ram_a_d      = ram_a;
    ram_dout_d   = ram_dout;
    ram_wr_d     = FALSE;
    if_done_d    = FALSE;
    mem_done_d   = FALSE;
    if_inst_d    = if_inst;
    if_pc_back_d = if_pc_back;
    mem_rdata_d  = mem_rdata;

    if (state == ST_IDLE) begin
      cnt_d = '0;
      buf_d = '0;
      if (mem_req) begin
        state_d    = ST_DATA;
        base_d     = mem_addr;
        n_d        = len_bytes(mem_len);
        we_d       = mem_we;
        wdata_d    = mem_wdata[31:8];
        ram_a_d    = mem_addr;
        ram_dout_d = mem_wdata[7:0];
        ram_wr_d   = mem_we;
      end else if (if_req && !if_flush) begin
        state_d      = ST_FETCH;
        base_d       = if_pc;
        n_d          = 3'd4;
        we_d         = FALSE;
        if_pc_back_d = if_pc;
        ram_a_d      = if_pc;
      end
    end else if (state == ST_FETCH && if_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state == ST_DATA && we_q) begin
      // cnt is the index of the byte strobed this cycle
      cnt_d = cnt_inc;
      if (cnt_inc < n_q) begin
        ram_a_d  = nxt_a;
        ram_wr_d = TRUE;
        case (cnt)
          3'd0:    ram_dout_d = wdata_q[7:0];
          3'd1:    ram_dout_d = wdata_q[15:8];
          default: ram_dout_d = wdata_q[23:16];
        endcase
      end else begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        mem_done_d = TRUE;
      end
    end else begin
      // read: address cnt is on ram_a, ram_din carries byte cnt-1
      cnt_d = cnt_inc;
      if (cnt_inc < n_q) ram_a_d = nxt_a;
      case (cnt)
        3'd1:    buf_d[7:0]   = ram_din;
        3'd2:    buf_d[15:8]  = ram_din;
        3'd3:    buf_d[23:16] = ram_din;
        3'd4:    buf_d[31:24] = ram_din;
        default: ;
      endcase
      if (cnt == n_q) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (state == ST_FETCH) begin
          if_done_d = TRUE;
          if_inst_d = buf_d;
        end else begin
          mem_done_d  = TRUE;
          mem_rdata_d = buf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter. The driver predicts every
// RAM bus cycle and every done pulse from the access rules and queues them;
// monitors compare what the DUT presents against those queues.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_ready, if_done;
  logic [31:0] if_inst, if_pc_back;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [1:0]  busy;
  logic [7:0]  ram_din = '0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_pc(if_pc), .if_flush(if_flush), .if_ready(if_ready),
    .if_done(if_done), .if_inst(if_inst), .if_pc_back(if_pc_back),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .busy(busy), .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
    .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vecs = 0;
  int errs = 0;

  typedef struct { int cyc; logic [31:0] a; logic wr; logic [7:0] d; } bus_t;
  typedef struct { int cyc; int kind; logic [31:0] data; logic [31:0] pc; } rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  // RAM contents: ram_mem is what the RAM really holds, ref_mem is the model
  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction
  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  // RAM: data for the address of cycle k appears on ram_din during cycle k+1
  logic [31:0] prev_a = '0;
  always @(negedge clk) begin
    ram_din = ram_rd(prev_a);
    if (ram_wr === 1'b1) ram_mem[ram_a] = ram_dout;
    prev_a = ram_a;
  end

  // bus monitor
  bus_t be;
  always @(negedge clk) begin
    if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
      be = bus_q.pop_front();
      vecs++;
      if (ram_a !== be.a || ram_wr !== be.wr || (be.wr && ram_dout !== be.d)) begin
        errs++;
        $display("FAIL bus cyc=%0d: got a=%h wr=%b d=%h, want a=%h wr=%b d=%h",
                 cyc, ram_a, ram_wr, ram_dout, be.a, be.wr, be.d);
      end
    end else if (ram_wr !== 1'b0 && !rst) begin
      errs++;
      $display("FAIL spurious_wr cyc=%0d: got wr=%b a=%h, want wr=0", cyc, ram_wr, ram_a);
    end
  end

  // completion monitor
  rsp_t re;
  logic ok;
  always @(negedge clk) begin
    if (if_done === 1'b1 || mem_done === 1'b1) begin
      vecs++;
      if (rsp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_done cyc=%0d: got if_done=%b mem_done=%b, want none",
                 cyc, if_done, mem_done);
      end else begin
        re = rsp_q.pop_front();
        if (re.kind == 0)
          ok = if_done && !mem_done && cyc == re.cyc && if_inst == re.data && if_pc_back == re.pc;
        else
          ok = mem_done && !if_done && cyc == re.cyc && (re.kind == 2 || mem_rdata == re.data);
        if (!ok) begin
          errs++;
          $display("FAIL done kind=%0d: got cyc=%0d if_done=%b mem_done=%b inst=%h pc=%h rdata=%h, want cyc=%0d data=%h pc=%h",
                   re.kind, cyc, if_done, mem_done, if_inst, if_pc_back, mem_rdata,
                   re.cyc, re.data, re.pc);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    logic [140:0] v;
    v = {ram_wr, ram_a, ram_dout, if_done, mem_done, if_inst, if_pc_back, mem_rdata, busy};
    vecs++;
    if (v !== '0) begin
      errs++;
      $display("FAIL %s: got outputs=%h, want all zero", name, v);
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store. flush_at: fetch-relative cycle of the
  // redirect (0 = none). dual: a fetch of pc2 is raised together with the data request.
  task automatic issue(input int kind, input logic [1:0] len, input logic [31:0] addr,
                       input logic [31:0] wd, input int flush_at, input bit dual,
                       input logic [31:0] pc2);
    int c, n, d;
    logic [31:0] exp;
    logic [7:0] b;
    c = cyc;
    n = (kind == 0) ? 4 : nbytes(len);
    if (kind == 0) begin
      if_req = 1'b1; if_pc = addr;
    end else begin
      mem_req = 1'b1; mem_we = (kind == 2); mem_len = len; mem_addr = addr; mem_wdata = wd;
      if (dual) begin if_req = 1'b1; if_pc = pc2; end
    end
    exp = '0;
    if (kind == 2) begin
      for (int i = 0; i < n; i++) begin
        b = 8'(wd >> (8 * i));
        bus_q.push_back('{c + 1 + i, addr + 32'(i), 1'b1, b});
        ref_mem[addr + 32'(i)] = b;
      end
      rsp_q.push_back('{c + n + 1, 2, 32'h0, 32'h0});
      d = c + n + 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        if (flush_at == 0 || i + 1 <= flush_at)
          bus_q.push_back('{c + 1 + i, addr + 32'(i), 1'b0, 8'h0});
        exp = exp | (32'(ref_rd(addr + 32'(i))) << (8 * i));
      end
      if (flush_at == 0) rsp_q.push_back('{c + n + 2, kind, exp, addr});
      d = c + n + 2;
    end
    if (dual) begin
      exp = '0;
      for (int i = 0; i < 4; i++) begin
        bus_q.push_back('{d + 1 + i, pc2 + 32'(i), 1'b0, 8'h0});
        exp = exp | (32'(ref_rd(pc2 + 32'(i))) << (8 * i));
      end
      rsp_q.push_back('{d + 6, 0, exp, pc2});
    end
    #1;
    vecs++;
    if (if_ready !== ((kind == 0) ? 1'b1 : 1'b0)) begin
      errs++;
      $display("FAIL if_ready cyc=%0d: got %b, want %b", c, if_ready, (kind == 0));
    end
    if (flush_at != 0) begin
      repeat (flush_at) @(negedge clk);
      if_flush = 1'b1; if_req = 1'b0;
      @(negedge clk);
      if_flush = 1'b0;
      vecs++;
      if (busy !== 2'd0) begin
        errs++;
        $display("FAIL flush_busy cyc=%0d: got %0d, want 0", cyc, busy);
      end
    end else begin
      for (int k = 0; k < 40 && (mem_req || if_req); k++) begin
        @(negedge clk);
        if (mem_done === 1'b1) mem_req = 1'b0;
        if (if_done === 1'b1) if_req = 1'b0;
      end
      if (mem_req || if_req) begin
        vecs++; errs++;
        $display("FAIL timeout cyc=%0d: got no done, want done by cycle %0d", cyc, d);
        mem_req = 1'b0; if_req = 1'b0;
        rsp_q.delete(); bus_q.delete();
        rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, fl, gap;
    bit dual;
    logic [1:0] len;
    logic [31:0] addr, pc2;
    logic [7:0] b;
    int c;

    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    ram_mem[32'h1000] = 8'h13; ref_mem[32'h1000] = 8'h13;
    for (int i = 1; i < 4; i++) begin
      ram_mem[32'h1000 + 32'(i)] = 8'h00; ref_mem[32'h1000 + 32'(i)] = 8'h00;
    end
    issue(0, 2'd0, 32'h1000, 32'h0, 0, 1'b0, 32'h0);
    issue(1, 2'd2, 32'h2000, 32'h0, 0, 1'b1, 32'h0);
    issue(2, 2'd1, 32'h3, 32'hBEEF, 0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    issue(0, 2'd0, 32'h40, 32'h0, 2, 1'b0, 32'h0);
    issue(0, 2'd0, 32'h80, 32'h0, 0, 1'b0, 32'h0);
    issue(1, 2'd0, 32'hFFFFFFFF, 32'h0, 0, 1'b0, 32'h0);
    issue(1, 2'd2, 32'hFFFFFFFE, 32'h0, 0, 1'b0, 32'h0);
    issue(1, 2'd1, 32'h3, 32'h0, 0, 1'b0, 32'h0);

    // redirect held in IDLE blocks the fetch grant
    @(negedge clk);
    if_pc = 32'h200; if_req = 1'b1; if_flush = 1'b1;
    #1;
    vecs++;
    if (if_ready !== 1'b0) begin
      errs++; $display("FAIL idle_flush_ready: got %b, want 0", if_ready);
    end
    repeat (2) begin
      @(negedge clk);
      vecs++;
      if (busy !== 2'd0) begin
        errs++; $display("FAIL idle_flush_busy cyc=%0d: got %0d, want 0", cyc, busy);
      end
    end
    if_flush = 1'b0;
    issue(0, 2'd0, 32'h200, 32'h0, 0, 1'b0, 32'h0);

    // reset in cycle 2 of a word store: two bytes land, nothing else
    @(negedge clk);
    c = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h120; mem_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      b = 8'(32'hCAFEF00D >> (8 * i));
      bus_q.push_back('{c + 1 + i, 32'h120 + 32'(i), 1'b1, b});
      ref_mem[32'h120 + 32'(i)] = b;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    repeat (4) @(negedge clk);
    issue(1, 2'd2, 32'h120, 32'h0, 0, 1'b0, 32'h0);

    for (int t = 0; t < 150; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      kind = $urandom_range(0, 2);
      len  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else addr = 32'h100 + 32'($urandom_range(0, 63));
      pc2  = 32'h100 + 32'($urandom_range(0, 63));
      fl   = (kind == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
      dual = (kind != 0 && $urandom_range(0, 4) == 0);
      issue(kind, len, addr, $urandom, fl, dual, pc2);
    end

    repeat (10) @(negedge clk);
    vecs++;
    if (rsp_q.size() != 0 || bus_q.size() != 0) begin
      errs++;
      $display("FAIL leftover: got %0d done / %0d bus pending, want 0 / 0",
               rsp_q.size(), bus_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 8-bit RAM port between the instruction-fetch stage and the MEM (load/store) stage. It sequences multi-byte accesses as consecutive single-byte RAM cycles and assembles or splits little-endian words. It also gives data accesses priority over fetch and lets the fetch side abort on a branch redirect. It sits between the IF/MEM stages and the external RAM and is the source of IF's address-needed, instruction-available and memory-busy signals.

## Interface
- ADDR_W, 32, address width of CPU requests and ram_a
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until if_done or if_flush
- if_pc  in  ADDR_W  fetch address
- if_flush  in  1  branch redirect; aborts or blocks fetch
- if_ready  out  1  arbiter can accept a fetch this cycle
- if_done  out  1  one-cycle pulse: if_inst/if_pc_back valid
- if_inst  out  32  fetched instruction
- if_pc_back  out  ADDR_W  address the delivered instruction came from
- mem_req  in  1  data request; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 2 = word, 3 treated as word
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  32  store data, low bytes used
- mem_done  out  1  one-cycle pulse: access complete, mem_rdata valid for loads
- mem_rdata  out  32  load data, zero-extended; sign extension is MEM's job
- busy  out  2  0 = idle, 1 = fetching, 2 = data access
- ram_din  in  8  RAM read data, valid the cycle after its address
- ram_dout  out  8  RAM write data
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe

## Operation
**States:** IDLE, FETCH, DATA. Byte counter cnt is 3 bits, 0..4. N is the byte count: 1, 2 or 4 for data, 4 for fetch.

**IDLE arbitration**, evaluated at each clock edge:
- mem_req → DATA. The request fields are latched and cnt is cleared.
- Otherwise, if_req && !if_flush → FETCH. if_pc is latched into if_pc_back and cnt is cleared.
- Data always wins. A fetch never preempts a data access.

**Address and data rules:**
- RAM address is base + cnt, modulo 2^ADDR_W; wrap past all-ones is legal.
- Byte i goes to or from bits [8i+7:8i], little-endian.

**Read sequence** (FETCH, or DATA with mem_we = 0):
- Drive ram_a for cnt = 0..N-1 on consecutive cycles, with ram_wr = 0.
- Capture ram_din one cycle after each address.
- After byte N-1 is captured, pulse done and return to IDLE.
- Unread upper bytes of mem_rdata are 0.

**Write sequence:**
- Drive ram_a, ram_dout = byte cnt and ram_wr = 1 for cnt = 0..N-1.
- Then pulse mem_done and return to IDLE.

**Flush:**
- if_flush in FETCH aborts the fetch: next state is IDLE, with no if_done and no captured data kept.
- if_flush in IDLE blocks fetch grant.
- if_flush in DATA has no effect.

**Outputs:**
- if_ready = (state == IDLE) && !mem_req && !if_flush.
- busy encodes the current state.
- Each grant produces exactly one done pulse (or abort). An instruction is never delivered twice.

## Timing
- Reset: state IDLE, cnt 0. All outputs are 0, including ram_wr, ram_a, ram_dout, if_done, mem_done, if_inst, if_pc_back, mem_rdata and busy.
- rst mid-operation abandons the access: no done pulse, ram_wr is 0 from the next cycle.
- Cycle numbering: the request is sampled high in IDLE at the end of cycle 0.
- Read:
  - Addresses are driven in cycles 1..N.
  - Bytes are valid on ram_din in cycles 2..N+1.
  - done is high in cycle N+2, with data registered.
  - A word fetch therefore has if_done in cycle 6.
- Write: strobes in cycles 1..N, mem_done in cycle N+1. A word store has mem_done in cycle 5.
- State is IDLE in the done cycle. A request held high is granted at the end of that cycle, giving back-to-back throughput of N+2 cycles for reads and N+1 for writes.
- Simultaneous mem_req and if_req in IDLE: DATA is granted. if_req stays pending and is granted after mem_done once mem_req is low.
- mem_req must drop in the cycle after mem_done; if it is still high it is treated as a new request.
- All outputs are registered except if_ready.

## Structure
- The shared defines package holds:
  - state codes (IDLE = 0, FETCH = 1, DATA = 2), which equal the busy codes;
  - mem_len codes LEN_B / LEN_H / LEN_W;
  - the True/False constants already used by the pipeline.
- Single module, no sub-module. The byte assembly and split logic is small enough to stay inline.

## Test plan
- Word fetch at 0x1000 with RAM bytes 13,00,00,00 → addresses 0x1000..0x1003 in cycles 1-4; if_done only in cycle 6 with if_inst = 0x00000013 and if_pc_back = 0x1000.
- mem_req (load word, 0x2000) and if_req (0x0) both rise in cycle 0 → DATA first, mem_done in cycle 6; fetch is granted at the end of cycle 6 and if_done comes in cycle 12.
- Store half 0xBEEF to 0x3 → ram_wr=1 with (0x3, EF) in cycle 1 and (0x4, BE) in cycle 2; mem_done in cycle 3; no further writes.
- Fetch at 0x40 with if_flush pulsed in cycle 2 → busy returns to 0 in cycle 3 and no if_done appears. A new fetch at 0x80 then completes with if_pc_back = 0x80.
- Load byte at 0xFFFFFFFF → one address; mem_rdata = 0x000000xx. Load word at 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 0, 1.
- rst asserted in cycle 2 of a word store → ram_wr = 0 from cycle 3 and all outputs 0. No mem_done follows, and the next request is accepted normally.
